// File: rtl/rescue_pkg.sv
// Shared types, constants and helper functions for the rescue dispatcher.
package rescue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SERVE    = 2'd1,
        ST_DISPATCH = 2'd2
    } state_t;

    localparam logic [1:0] PRIO_LOW    = 2'd0;
    localparam logic [1:0] PRIO_MEDIUM = 2'd1;
    localparam logic [1:0] PRIO_HIGH   = 2'd2;
    localparam logic [1:0] PRIO_URGENT = 2'd3;

    localparam int DEF_NUM_TEAMS = 4;
    localparam int DEF_BASE_TIME = 4;

    // Higher priority means a shorter mission: (4 - prio) * base cycles.
    function automatic logic [7:0] mission_duration(input logic [1:0] prio, input int base);
        logic [7:0] d;
        case (prio)
            PRIO_URGENT: d = 8'(base);
            PRIO_HIGH:   d = 8'(2 * base);
            PRIO_MEDIUM: d = 8'(3 * base);
            default:     d = 8'(4 * base);
        endcase
        return d;
    endfunction

    function automatic logic [1:0] lowest_free(input logic [3:0] busy);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!busy[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rescue_dispatch_team_timer.sv
// Per-team mission timer: loads a duration, counts down to zero, busy while nonzero.
module team_timer (
    input  logic       Main_Clock,
    input  logic       Reset,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic       busy
);

    logic [7:0] count;

    always_ff @(posedge Main_Clock) begin
        if (Reset)
            count <= 8'd0;
        else if (load)
            count <= load_value;
        else if (count != 8'd0)
            count <= count - 8'd1;
    end

    assign busy = (count != 8'd0);

endmodule

// File: rtl/rescue_dispatch.sv
// Pops the evacuation queue head and assigns it to the lowest-index free rescue team.
module rescue_dispatch
    import rescue_pkg::*;
#(
    parameter int NUM_TEAMS = DEF_NUM_TEAMS,
    parameter int BASE_TIME = DEF_BASE_TIME
) (
    input  logic                 Main_Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic [7:0]           Queue_Zone,
    input  logic [1:0]           Queue_Priority,
    input  logic                 Queue_Empty,
    output logic                 Serve,
    output logic                 Dispatch_Valid,
    output logic [1:0]           Dispatch_Team,
    output logic [7:0]           Dispatch_Zone,
    output logic [1:0]           Dispatch_Priority,
    output logic [NUM_TEAMS-1:0] Team_Busy,
    output logic [7:0]           Mission_Count
);

    state_t               state, state_next;
    logic [7:0]           cap_zone;
    logic [1:0]           cap_prio;
    logic [1:0]           cap_team;
    logic [NUM_TEAMS-1:0] busy;
    logic [NUM_TEAMS-1:0] load;
    logic [3:0]           busy_pad;
    logic [7:0]           load_value;
    logic                 start;

    // Teams that do not exist look permanently busy to the encoder.
    always_comb begin
        busy_pad                 = '1;
        busy_pad[NUM_TEAMS-1:0]  = busy;
        start                    = Enable && !Queue_Empty && !(&busy);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (start) state_next = ST_SERVE;
            ST_SERVE:    state_next = ST_DISPATCH;
            ST_DISPATCH: state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Main_Clock) begin
        if (Reset) begin
            state             <= ST_IDLE;
            Serve             <= 1'b0;
            Dispatch_Valid    <= 1'b0;
            cap_zone          <= 8'd0;
            cap_prio          <= 2'd0;
            cap_team          <= 2'd0;
            Dispatch_Team     <= 2'd0;
            Dispatch_Zone     <= 8'd0;
            Dispatch_Priority <= 2'd0;
            Mission_Count     <= 8'd0;
        end else begin
            state          <= state_next;
            Serve          <= (state_next == ST_SERVE);
            Dispatch_Valid <= (state_next == ST_DISPATCH);
            if (state == ST_IDLE && start) begin
                cap_zone <= Queue_Zone;
                cap_prio <= Queue_Priority;
                cap_team <= lowest_free(busy_pad);
            end
            if (state == ST_SERVE) begin
                Dispatch_Team     <= cap_team;
                Dispatch_Zone     <= cap_zone;
                Dispatch_Priority <= cap_prio;
            end
            if (state == ST_DISPATCH && Mission_Count != 8'hFF)
                Mission_Count <= Mission_Count + 8'd1;
        end
    end

    // Timer load lands on the SERVE->DISPATCH edge so busy rises with Dispatch_Valid.
    always_comb begin
        load       = '0;
        load_value = mission_duration(cap_prio, BASE_TIME);
        for (int i = 0; i < NUM_TEAMS; i++)
            load[i] = (state == ST_SERVE) && (cap_team == 2'(i));
    end

    for (genvar g = 0; g < NUM_TEAMS; g++) begin : g_team
        team_timer u_timer (
            .Main_Clock (Main_Clock),
            .Reset      (Reset),
            .load       (load[g]),
            .load_value (load_value),
            .busy       (busy[g])
        );
    end

    assign Team_Busy = busy;

endmodule

// File: tb/tb_rescue_dispatch.sv
// Directed-vector bench for rescue_dispatch with a simple FIFO model standing in for the queue.
module tb_rescue_dispatch;

    logic       Main_Clock = 1'b0;
    logic       Reset      = 1'b1;
    logic       Enable     = 1'b0;
    logic [7:0] Queue_Zone;
    logic [1:0] Queue_Priority;
    logic       Queue_Empty;
    logic       Serve;
    logic       Dispatch_Valid;
    logic [1:0] Dispatch_Team;
    logic [7:0] Dispatch_Zone;
    logic [1:0] Dispatch_Priority;
    logic [3:0] Team_Busy;
    logic [7:0] Mission_Count;

    int checks   = 0;
    int failures = 0;

    always #5 Main_Clock = ~Main_Clock;

    rescue_dispatch #(.NUM_TEAMS(4), .BASE_TIME(4)) dut (
        .Main_Clock        (Main_Clock),
        .Reset             (Reset),
        .Enable            (Enable),
        .Queue_Zone        (Queue_Zone),
        .Queue_Priority    (Queue_Priority),
        .Queue_Empty       (Queue_Empty),
        .Serve             (Serve),
        .Dispatch_Valid    (Dispatch_Valid),
        .Dispatch_Team     (Dispatch_Team),
        .Dispatch_Zone     (Dispatch_Zone),
        .Dispatch_Priority (Dispatch_Priority),
        .Team_Busy         (Team_Busy),
        .Mission_Count     (Mission_Count)
    );

    // Queue model: head is combinational, pops on each edge where Serve was high.
    logic [7:0] qz [0:1023];
    logic [1:0] qp [0:1023];
    int qh = 0;
    int qt = 0;

    assign Queue_Empty    = (qh == qt);
    assign Queue_Zone     = qz[qh % 1024];
    assign Queue_Priority = qp[qh % 1024];

    always @(posedge Main_Clock) if (Serve) qh <= qh + 1;

    task automatic push(input logic [7:0] z, input logic [1:0] p);
        qz[qt % 1024] = z;
        qp[qt % 1024] = p;
        qt = qt + 1;
    endtask

    task automatic tick();
        @(posedge Main_Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset  = 1'b1;
        Enable = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (Serve !== 1'b0 || Dispatch_Valid !== 1'b0 || Team_Busy !== 4'b0000 ||
                Mission_Count !== 8'd0 || Dispatch_Team !== 2'd0 || Dispatch_Zone !== 8'd0 ||
                Dispatch_Priority !== 2'd0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d serve=%b valid=%b busy=%b count=%0d team=%0d zone=%h prio=%0d, expected all zero",
                         i, Serve, Dispatch_Valid, Team_Busy, Mission_Count, Dispatch_Team, Dispatch_Zone, Dispatch_Priority);
            end
        end
    endtask

    task automatic test_single();
        push(8'h12, 2'd3);
        tick();
        checks++;
        if (Serve !== 1'b1 || Dispatch_Valid !== 1'b0) begin
            failures++;
            $display("FAIL single_serve serve=%b valid=%b, expected 1/0", Serve, Dispatch_Valid);
        end
        tick();
        checks++;
        if (Serve !== 1'b0 || Dispatch_Valid !== 1'b1 || Dispatch_Team !== 2'd0 ||
            Dispatch_Zone !== 8'h12 || Dispatch_Priority !== 2'd3 || Team_Busy !== 4'b0001) begin
            failures++;
            $display("FAIL single_dispatch serve=%b valid=%b team=%0d zone=%h prio=%0d busy=%b, expected 0 1 0 12 3 0001",
                     Serve, Dispatch_Valid, Dispatch_Team, Dispatch_Zone, Dispatch_Priority, Team_Busy);
        end
        for (int k = 1; k < 4; k++) begin
            tick();
            checks++;
            if (Team_Busy !== 4'b0001 || Dispatch_Valid !== 1'b0 || Mission_Count !== 8'd1 ||
                Dispatch_Zone !== 8'h12) begin
                failures++;
                $display("FAIL single_busy k=%0d busy=%b valid=%b count=%0d zone=%h, expected 0001 0 1 12",
                         k, Team_Busy, Dispatch_Valid, Mission_Count, Dispatch_Zone);
            end
        end
        tick();
        checks++;
        if (Team_Busy !== 4'b0000) begin
            failures++;
            $display("FAIL single_free busy=%b, expected 0000", Team_Busy);
        end
    endtask

    task automatic test_all_teams();
        int exp_cyc [5];
        int exp_team [5];
        int nd;
        exp_cyc  = '{2, 5, 8, 11, 20};
        exp_team = '{0, 1, 2, 3, 0};
        nd = 0;
        for (int i = 0; i < 5; i++) push(8'h20 + 8'(i), 2'd0);
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (Dispatch_Valid === 1'b1) begin
                if (nd < 5) begin
                    checks++;
                    if (c != exp_cyc[nd] || Dispatch_Team !== 2'(exp_team[nd]) ||
                        Dispatch_Zone !== 8'h20 + 8'(nd) || Dispatch_Priority !== 2'd0) begin
                        failures++;
                        $display("FAIL teams_dispatch n=%0d cyc=%0d team=%0d zone=%h prio=%0d, expected cyc=%0d team=%0d zone=%h prio=0",
                                 nd, c, Dispatch_Team, Dispatch_Zone, Dispatch_Priority,
                                 exp_cyc[nd], exp_team[nd], 8'h20 + 8'(nd));
                    end
                end
                nd++;
            end
            if (c == 12) begin
                checks++;
                if (Team_Busy !== 4'b1111 || Serve !== 1'b0) begin
                    failures++;
                    $display("FAIL teams_all_busy busy=%b serve=%b, expected 1111 0", Team_Busy, Serve);
                end
            end
        end
        checks++;
        if (nd != 5 || Mission_Count !== 8'd6) begin
            failures++;
            $display("FAIL teams_total dispatches=%0d count=%0d, expected 5 6", nd, Mission_Count);
        end
    endtask

    task automatic test_enable_drop();
        int serves;
        push(8'h40, 2'd3);
        push(8'h41, 2'd3);
        tick();
        checks++;
        if (Serve !== 1'b1) begin
            failures++;
            $display("FAIL en_serve serve=%b, expected 1", Serve);
        end
        Enable = 1'b0;
        tick();
        checks++;
        if (Dispatch_Valid !== 1'b1 || Dispatch_Zone !== 8'h40 || Dispatch_Team !== 2'd0) begin
            failures++;
            $display("FAIL en_complete valid=%b zone=%h team=%0d, expected 1 40 0", Dispatch_Valid, Dispatch_Zone, Dispatch_Team);
        end
        serves = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (Serve === 1'b1) serves++;
        end
        checks++;
        if (serves != 0) begin
            failures++;
            $display("FAIL en_hold serves=%0d, expected 0", serves);
        end
        Enable = 1'b1;
        tick();
        checks++;
        if (Serve !== 1'b1) begin
            failures++;
            $display("FAIL en_resume serve=%b, expected 1", Serve);
        end
        tick();
        checks++;
        if (Dispatch_Valid !== 1'b1 || Dispatch_Zone !== 8'h41 || Dispatch_Team !== 2'd0 || Dispatch_Priority !== 2'd3) begin
            failures++;
            $display("FAIL en_second valid=%b zone=%h team=%0d prio=%0d, expected 1 41 0 3",
                     Dispatch_Valid, Dispatch_Zone, Dispatch_Team, Dispatch_Priority);
        end
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset_mid();
        push(8'h55, 2'd1);
        tick();
        tick();
        checks++;
        if (Dispatch_Valid !== 1'b1 || Team_Busy !== 4'b0001) begin
            failures++;
            $display("FAIL midrst_pre valid=%b busy=%b, expected 1 0001", Dispatch_Valid, Team_Busy);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (Dispatch_Valid !== 1'b0 || Serve !== 1'b0 || Team_Busy !== 4'b0000 || Mission_Count !== 8'd0 ||
            Dispatch_Team !== 2'd0 || Dispatch_Zone !== 8'd0 || Dispatch_Priority !== 2'd0) begin
            failures++;
            $display("FAIL midrst_post valid=%b serve=%b busy=%b count=%0d team=%0d zone=%h prio=%0d, expected all zero",
                     Dispatch_Valid, Serve, Team_Busy, Mission_Count, Dispatch_Team, Dispatch_Zone, Dispatch_Priority);
        end
        tick();
        checks++;
        if (Serve !== 1'b0 || Queue_Empty !== 1'b1) begin
            failures++;
            $display("FAIL midrst_idle serve=%b empty=%b, expected 0 1", Serve, Queue_Empty);
        end
    endtask

    task automatic test_saturate();
        int nd;
        int cyc;
        nd  = 0;
        cyc = 0;
        for (int i = 0; i < 256; i++) push(8'(i), 2'd3);
        while (nd < 256 && cyc < 2000) begin
            tick();
            cyc++;
            if (Dispatch_Valid === 1'b1) nd++;
        end
        checks++;
        if (nd != 256) begin
            failures++;
            $display("FAIL sat_timeout dispatches=%0d, expected 256", nd);
        end
        checks++;
        if (Mission_Count !== 8'd255 || Dispatch_Zone !== 8'd255) begin
            failures++;
            $display("FAIL sat_255 count=%0d zone=%0d, expected 255 255", Mission_Count, Dispatch_Zone);
        end
        tick();
        checks++;
        if (Mission_Count !== 8'd255) begin
            failures++;
            $display("FAIL sat_hold count=%0d, expected 255", Mission_Count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_teams();
        test_enable_drop();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
